// File: rtl/combined_memory_if.sv
// Write-data/enable bundle and register/RAM read-back for combined_memory.
interface combined_memory_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] x;
    logic             a_we;
    logic             d_we;
    logic             m_we;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] d_out;
    logic [WIDTH-1:0] m_out;
    logic             ready;

    modport master (
        output x, a_we, d_we, m_we,
        input  a_out, d_out, m_out, ready
    );

    modport slave (
        input  x, a_we, d_we, m_we,
        output a_out, d_out, m_out, ready
    );
endinterface

// File: rtl/combined_memory.sv
// A and D registers plus a word-addressed RAM indexed by A, with a post-reset
// clear sequencer that zeroes the RAM before any write is accepted.
module combined_memory #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    combined_memory_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       d_q, d_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic [WIDTH-1:0]       mem_wdata;
    logic [ADDR_BITS-1:0]   a_idx;

    // Upper A bits never reach the RAM, so addresses alias modulo DEPTH.
    assign a_idx = a_q[ADDR_BITS-1:0];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        d_d       = d_q;
        mem_we    = 1'b0;
        mem_addr  = a_idx;
        mem_wdata = bus.x;
        unique case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = '0;
                idx_d     = idx_q + ADDR_BITS'(1);
                if (&idx_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // RAM write addresses through the pre-edge A even when A loads.
                mem_we = bus.m_we;
                if (bus.a_we) begin
                    a_d = bus.x;
                end
                if (bus.d_we) begin
                    d_d = bus.x;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            d_q     <= d_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign bus.a_out = a_q;
    assign bus.d_out = d_q;
    assign bus.ready = (state_q == RUN);
    assign bus.m_out = (state_q == RUN) ? mem_q[a_idx] : '0;
endmodule

// File: tb/tb_combined_memory.sv
// Scoreboard bench for combined_memory: a driver applies one operation per
// cycle and queues the expected post-edge view; a monitor compares it.
module tb_combined_memory;
    localparam int WIDTH     = 16;
    localparam int ADDR_BITS = 4;
    localparam int DEPTH     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    combined_memory_if #(.WIDTH(WIDTH)) bus ();

    combined_memory #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] m;
        logic             rdy;
        string            tag;
    } exp_t;

    exp_t q[$];

    // Reference model: registers, RAM image and number of clear edges seen.
    logic [WIDTH-1:0] ma, md;
    logic [WIDTH-1:0] mmem [DEPTH];
    int               cleared;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input string tag,
                       input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s at %0t: got %h, expected %h", tag, name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic aw, input logic dw, input logic mw,
                        input logic [WIDTH-1:0] xv, input string tag);
        exp_t e;
        @(negedge clk);
        rst      = r;
        bus.a_we = aw;
        bus.d_we = dw;
        bus.m_we = mw;
        bus.x    = xv;
        if (r) begin
            ma = '0;
            md = '0;
            cleared = 0;
        end else if (cleared < DEPTH) begin
            mmem[cleared] = '0;
            cleared++;
        end else begin
            if (mw) mmem[int'(ma) % DEPTH] = xv;
            if (aw) ma = xv;
            if (dw) md = xv;
        end
        e.a   = ma;
        e.d   = md;
        e.rdy = (cleared == DEPTH);
        e.m   = e.rdy ? mmem[int'(ma) % DEPTH] : '0;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, tag);
    endtask

    task automatic load_a(input logic [WIDTH-1:0] v, input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b0, v, tag);
    endtask

    // Monitor samples 1 time unit after each rising edge; inputs change at negedge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("a_out", e.tag, bus.a_out, e.a);
                cmp("d_out", e.tag, bus.d_out, e.d);
                cmp("m_out", e.tag, bus.m_out, e.m);
                cmp("ready", e.tag, {15'd0, bus.ready}, {15'd0, e.rdy});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bus.x    = '0;
        bus.a_we = 1'b0;
        bus.d_we = 1'b0;
        bus.m_we = 1'b0;
        ma = '0;
        md = '0;
        cleared = 0;

        // Clear sequence with m_we/x held active.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "rst");
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "rst");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, "clear");
        idle(1, "post_clear");
        for (int i = 0; i < DEPTH; i++) load_a(16'(i), "sweep");

        // Basic writes.
        load_a(16'h0005, "basic_a");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, "basic_m");
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, "basic_d");

        // Simultaneous A and M write uses the old A.
        load_a(16'h0007, "sim_prep");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h00AA, "sim_prep");
        load_a(16'h0003, "sim_prep");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0007, "sim_am");
        load_a(16'h0003, "sim_reload");

        // Aliasing on the low address bits.
        load_a(16'h0013, "alias_a");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h5A5A, "alias_m");
        load_a(16'h0003, "alias_rd");

        // Reset mid-INIT with register writes attempted during the clear.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "rst_mid");
        idle(9, "init9");
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "rst_mid");
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'(i % 2), 1'(i % 3 == 0), 1'b1, 16'hC0DE, "init_we");
        idle(2, "init_done");

        // Reset while running.
        load_a(16'h0002, "run_fill");
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, "run_fill");
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h2222, "run_fill");
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "rst_run");
        idle(DEPTH, "reclear");
        load_a(16'h0002, "reclear_rd");

        // Randomised traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 16'($urandom), "random");
        end
        idle(2, "tail");

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
